// File: rtl/multiport_register_file_if.sv
// Decode/writeback-side bundle of the multiport register file: read indices and
// data, the two write ports, load reservations and the PC hand-off.
interface multiport_register_file_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int NUM_READ = 3,
  parameter int ADDR_W   = $clog2(NUM_REGS)
);
  logic [NUM_READ*ADDR_W-1:0] readRegs;
  logic [NUM_READ*DATA_W-1:0] readData;
  logic [NUM_READ-1:0]        readPending;
  logic                       writeEnable0;
  logic [ADDR_W-1:0]          writeDest0;
  logic [DATA_W-1:0]          writeData0;
  logic                       writeEnable1;
  logic [ADDR_W-1:0]          writeDest1;
  logic [DATA_W-1:0]          writeData1;
  logic                       reserveEn;
  logic [ADDR_W-1:0]          reserveReg;
  logic [DATA_W-1:0]          pcIn;
  logic                       writeToPC;
  logic [DATA_W-1:0]          pcWriteData;

  modport master (
    output readRegs, writeEnable0, writeDest0, writeData0,
           writeEnable1, writeDest1, writeData1, reserveEn, reserveReg, pcIn,
    input  readData, readPending, writeToPC, pcWriteData
  );

  modport slave (
    input  readRegs, writeEnable0, writeDest0, writeData0,
           writeEnable1, writeDest1, writeData1, reserveEn, reserveReg, pcIn,
    output readData, readPending, writeToPC, pcWriteData
  );
endinterface

// File: rtl/multiport_register_file.sv
// Multiport register file: NUM_REGS-1 stored registers (the top index is the PC,
// owned by the program counter), two write ports with port 0 priority, same-cycle
// write-through bypass on every read port, a pending-load scoreboard and a
// registered PC-write pulse.
module multiport_register_file #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int NUM_READ  = 3,
  parameter int PC_OFFSET = 8,
  parameter int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  multiport_register_file_if.slave rf
);
  localparam int                NSTORE = NUM_REGS - 1;
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] regs_q [NSTORE];
  logic [DATA_W-1:0] regs_d [NSTORE];
  logic [NSTORE-1:0] pend_q, pend_d;
  logic              wtp_q, wtp_d;
  logic [DATA_W-1:0] pcw_q, pcw_d;
  logic              pc_wr0, pc_wr1;

  assign pc_wr0 = rf.writeEnable0 && (rf.writeDest0 == PC_IDX);
  assign pc_wr1 = rf.writeEnable1 && (rf.writeDest1 == PC_IDX);

  // Register array and scoreboard next state; port 0 applied after port 1 so it wins,
  // and a reservation applied after the load clear so it wins.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int r = 0; r < NSTORE; r++) begin
      if (rf.writeEnable1 && (rf.writeDest1 == ADDR_W'(r))) begin
        regs_d[r] = rf.writeData1;
        pend_d[r] = 1'b0;
      end
      if (rf.writeEnable0 && (rf.writeDest0 == ADDR_W'(r))) begin
        regs_d[r] = rf.writeData0;
      end
      if (rf.reserveEn && (rf.reserveReg == ADDR_W'(r))) begin
        pend_d[r] = 1'b1;
      end
    end
  end

  // PC hand-off next state: pulse on any PC write, data held between writes.
  always_comb begin
    wtp_d = pc_wr0 || pc_wr1;
    pcw_d = pcw_q;
    if (pc_wr0) begin
      pcw_d = rf.writeData0;
    end else if (pc_wr1) begin
      pcw_d = rf.writeData1;
    end
  end

  // State registers with asynchronous clear of data, scoreboard and PC pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NSTORE; r++) begin
        regs_q[r] <= '0;
      end
      pend_q <= '0;
      wtp_q  <= 1'b0;
      pcw_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      wtp_q  <= wtp_d;
      pcw_q  <= pcw_d;
    end
  end

  assign rf.writeToPC   = wtp_q;
  assign rf.pcWriteData = pcw_q;

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_pend;

    assign rd_addr = rf.readRegs[gi*ADDR_W +: ADDR_W];

    // Read mux: PC view first, then same-cycle bypass (port 0 first), then storage;
    // indices beyond the PC read as zero and are never pending.
    always_comb begin
      rd_data = '0;
      rd_pend = 1'b0;
      if (rd_addr == PC_IDX) begin
        rd_data = rf.pcIn + DATA_W'(PC_OFFSET);
      end else if (rd_addr < PC_IDX) begin
        for (int r = 0; r < NSTORE; r++) begin
          if (rd_addr == ADDR_W'(r)) begin
            rd_data = regs_q[r];
            rd_pend = pend_q[r];
          end
        end
        if (rf.writeEnable0 && (rf.writeDest0 == rd_addr)) begin
          rd_data = rf.writeData0;
        end else if (rf.writeEnable1 && (rf.writeDest1 == rd_addr)) begin
          rd_data = rf.writeData1;
        end
        if (rf.writeEnable1 && (rf.writeDest1 == rd_addr)) begin
          rd_pend = 1'b0;
        end
      end
    end

    assign rf.readData[gi*DATA_W +: DATA_W] = rd_data;
    assign rf.readPending[gi]               = rd_pend;
  end
endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: a 32-bit/16-reg/3-port instance (A) and a
// 16-bit/8-reg/4-port instance (B) share clock and reset.
module tb_multiport_register_file;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multiport_register_file_if #(.DATA_W(32), .NUM_REGS(16), .NUM_READ(3)) ifa ();
  multiport_register_file_if #(.DATA_W(16), .NUM_REGS(8),  .NUM_READ(4)) ifb ();

  multiport_register_file #(.DATA_W(32), .NUM_REGS(16), .NUM_READ(3), .PC_OFFSET(8))
    dut_a (.clk(clk), .reset(reset), .rf(ifa));
  multiport_register_file #(.DATA_W(16), .NUM_REGS(8), .NUM_READ(4), .PC_OFFSET(8))
    dut_b (.clk(clk), .reset(reset), .rf(ifb));

  int n_chk = 0;
  int n_fail = 0;

  // stimulus, per configuration c (0 = A, 1 = B)
  int unsigned s_we0[2], s_d0[2], s_dat0[2], s_we1[2], s_d1[2], s_dat1[2];
  int unsigned s_res[2], s_rreg[2], s_pc[2];
  int unsigned s_rr[2][4];

  // reference model state
  int unsigned m_reg[2][16];
  int unsigned m_pend[2][16];
  int unsigned m_wtp[2], m_pcw[2];

  typedef struct {
    int unsigned we0, d0, dat0, we1, d1, dat1, res, rreg, pc, rr0, rr1;
    int unsigned e_rd0, e_rd1, e_p0, e_p1, e_wtp, e_pcw;
  } vec_t;
  vec_t tbl[13];

  function automatic int unsigned nregs(int c);
    return (c == 0) ? 16 : 8;
  endfunction

  function automatic int unsigned nread(int c);
    return (c == 0) ? 3 : 4;
  endfunction

  function automatic int unsigned dmask(int c);
    return (c == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic int unsigned exp_rd(int c, int unsigned a);
    int unsigned pcix = nregs(c) - 1;
    if (a == pcix) return (s_pc[c] + 8) & dmask(c);
    if (a > pcix) return 0;
    if (s_we0[c] != 0 && s_d0[c] == a) return s_dat0[c];
    if (s_we1[c] != 0 && s_d1[c] == a) return s_dat1[c];
    return m_reg[c][a];
  endfunction

  function automatic int unsigned exp_pend(int c, int unsigned a);
    if (a >= nregs(c) - 1) return 0;
    if (s_we1[c] != 0 && s_d1[c] == a) return 0;
    return m_pend[c][a];
  endfunction

  function automatic int unsigned act_rd(int c, int i);
    if (c == 0) return 32'(ifa.readData[i*32 +: 32]);
    return 32'(ifb.readData[i*16 +: 16]);
  endfunction

  function automatic int unsigned act_pend(int c, int i);
    if (c == 0) return 32'(ifa.readPending[i]);
    return 32'(ifb.readPending[i]);
  endfunction

  function automatic int unsigned act_wtp(int c);
    return (c == 0) ? 32'(ifa.writeToPC) : 32'(ifb.writeToPC);
  endfunction

  function automatic int unsigned act_pcw(int c);
    return (c == 0) ? 32'(ifa.pcWriteData) : 32'(ifb.pcWriteData);
  endfunction

  task automatic chk(string name, int unsigned act, int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(int c);
    s_we0[c] = 0; s_d0[c] = 0; s_dat0[c] = 0;
    s_we1[c] = 0; s_d1[c] = 0; s_dat1[c] = 0;
    s_res[c] = 0; s_rreg[c] = 0; s_pc[c] = 0;
    for (int i = 0; i < 4; i++) s_rr[c][i] = 0;
  endtask

  task automatic drive();
    ifa.writeEnable0 = (s_we0[0] != 0); ifa.writeDest0 = 4'(s_d0[0]); ifa.writeData0 = s_dat0[0];
    ifa.writeEnable1 = (s_we1[0] != 0); ifa.writeDest1 = 4'(s_d1[0]); ifa.writeData1 = s_dat1[0];
    ifa.reserveEn = (s_res[0] != 0); ifa.reserveReg = 4'(s_rreg[0]); ifa.pcIn = s_pc[0];
    for (int i = 0; i < 3; i++) ifa.readRegs[i*4 +: 4] = 4'(s_rr[0][i]);
    ifb.writeEnable0 = (s_we0[1] != 0); ifb.writeDest0 = 3'(s_d0[1]); ifb.writeData0 = 16'(s_dat0[1]);
    ifb.writeEnable1 = (s_we1[1] != 0); ifb.writeDest1 = 3'(s_d1[1]); ifb.writeData1 = 16'(s_dat1[1]);
    ifb.reserveEn = (s_res[1] != 0); ifb.reserveReg = 3'(s_rreg[1]); ifb.pcIn = 16'(s_pc[1]);
    for (int i = 0; i < 4; i++) ifb.readRegs[i*3 +: 3] = 3'(s_rr[1][i]);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 16; r++) begin
        m_reg[c][r] = 0;
        m_pend[c][r] = 0;
      end
      m_wtp[c] = 0;
      m_pcw[c] = 0;
    end
  endtask

  // state update for one rising edge, from the inputs present at that edge
  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      int unsigned pcix;
      pcix = nregs(c) - 1;
      m_wtp[c] = 0;
      if (s_we1[c] != 0) begin
        if (s_d1[c] < pcix) begin
          m_reg[c][s_d1[c]] = s_dat1[c];
          m_pend[c][s_d1[c]] = 0;
        end else if (s_d1[c] == pcix) begin
          m_wtp[c] = 1;
          m_pcw[c] = s_dat1[c];
        end
      end
      if (s_we0[c] != 0) begin
        if (s_d0[c] < pcix) m_reg[c][s_d0[c]] = s_dat0[c];
        else if (s_d0[c] == pcix) begin
          m_wtp[c] = 1;
          m_pcw[c] = s_dat0[c];
        end
      end
      if (s_res[c] != 0 && s_rreg[c] < pcix) m_pend[c][s_rreg[c]] = 1;
    end
  endtask

  task automatic check_all(string tag);
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < int'(nread(c)); i++) begin
        chk($sformatf("%s c%0d rd%0d", tag, c, i), act_rd(c, i), exp_rd(c, s_rr[c][i]));
        chk($sformatf("%s c%0d pend%0d", tag, c, i), act_pend(c, i), exp_pend(c, s_rr[c][i]));
      end
      chk($sformatf("%s c%0d writeToPC", tag, c), act_wtp(c), m_wtp[c]);
      chk($sformatf("%s c%0d pcWriteData", tag, c), act_pcw(c), m_pcw[c]);
    end
  endtask

  task automatic rand_stim(int c);
    int unsigned n, msk;
    n = nregs(c);
    msk = dmask(c);
    s_we0[c] = $urandom_range(0, 1);
    s_d0[c] = $urandom_range(0, n - 1);
    s_dat0[c] = $urandom & msk;
    s_we1[c] = ($urandom_range(0, 2) == 0) ? 1 : 0;
    s_d1[c] = $urandom_range(0, n - 1);
    s_dat1[c] = $urandom & msk;
    s_res[c] = ($urandom_range(0, 2) == 0) ? 1 : 0;
    s_rreg[c] = $urandom_range(0, n - 1);
    s_pc[c] = ($urandom_range(0, 3) == 0) ? (msk - $urandom_range(0, 15)) : ($urandom & msk);
    for (int i = 0; i < 4; i++) s_rr[c][i] = $urandom_range(0, n - 1);
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required below 200000", $time);
    $fatal(1);
  end

  initial begin
    //             we0 d0 dat0          we1 d1 dat1   res rg pc            rr0 rr1 | rd0           rd1           p0 p1 wtp pcw
    tbl[0]  = '{1, 8, 32'hAAAAAAAA, 0, 0, 0,      0, 0, 0,            8,  8,  32'hAAAAAAAA, 32'hAAAAAAAA, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0,            0, 0, 0,      0, 0, 0,            8,  3,  32'hAAAAAAAA, 0,            0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0,            0, 0, 0,      1, 2, 0,            2,  8,  0,            32'hAAAAAAAA, 0, 0, 0, 0};
    tbl[3]  = '{1, 2, 32'h11,       1, 2, 32'h22, 0, 0, 0,            2,  2,  32'h11,       32'h11,       0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0,            0, 0, 0,      1, 5, 0,            2,  5,  32'h11,       0,            0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0,            0, 0, 0,      0, 0, 0,            5,  5,  0,            0,            1, 1, 0, 0};
    tbl[6]  = '{0, 0, 0,            1, 5, 32'hCC, 1, 5, 0,            5,  2,  32'hCC,       32'h11,       0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0,            0, 0, 0,      0, 0, 32'h100,      5,  15, 32'hCC,       32'h108,      1, 0, 0, 0};
    tbl[8]  = '{0, 0, 0,            1, 5, 32'hDD, 0, 0, 32'hFFFFFFFC, 5,  15, 32'hDD,       32'h4,        0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0,            1, 15, 32'h200, 0, 0, 0,          5,  15, 32'hDD,       32'h8,        0, 0, 0, 0};
    tbl[10] = '{1, 15, 32'h300,     1, 15, 32'h400, 0, 0, 32'h10,     15, 8,  32'h18,       32'hAAAAAAAA, 0, 0, 1, 32'h200};
    tbl[11] = '{0, 0, 0,            0, 0, 0,      1, 15, 0,           8,  2,  32'hAAAAAAAA, 32'h11,       0, 0, 1, 32'h300};
    tbl[12] = '{0, 0, 0,            0, 0, 0,      0, 0, 0,            15, 5,  32'h8,        32'hDD,       0, 0, 0, 32'h300};

    // reset state
    idle(0); idle(1); model_reset(); drive();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    edge_step();

    // directed table on instance A
    for (int k = 0; k < 13; k++) begin
      idle(0); idle(1);
      s_we0[0] = tbl[k].we0; s_d0[0] = tbl[k].d0; s_dat0[0] = tbl[k].dat0;
      s_we1[0] = tbl[k].we1; s_d1[0] = tbl[k].d1; s_dat1[0] = tbl[k].dat1;
      s_res[0] = tbl[k].res; s_rreg[0] = tbl[k].rreg; s_pc[0] = tbl[k].pc;
      s_rr[0][0] = tbl[k].rr0; s_rr[0][1] = tbl[k].rr1;
      drive();
      @(negedge clk);
      chk($sformatf("tbl%0d rd0", k), act_rd(0, 0), tbl[k].e_rd0);
      chk($sformatf("tbl%0d rd1", k), act_rd(0, 1), tbl[k].e_rd1);
      chk($sformatf("tbl%0d pend0", k), act_pend(0, 0), tbl[k].e_p0);
      chk($sformatf("tbl%0d pend1", k), act_pend(0, 1), tbl[k].e_p1);
      chk($sformatf("tbl%0d writeToPC", k), act_wtp(0), tbl[k].e_wtp);
      chk($sformatf("tbl%0d pcWriteData", k), act_pcw(0), tbl[k].e_pcw);
      edge_step();
    end

    // asynchronous reset in the middle of a cycle
    idle(0); idle(1);
    s_we0[0] = 1; s_d0[0] = 3; s_dat0[0] = 32'h12345678;
    s_we1[0] = 1; s_d1[0] = 15; s_dat1[0] = 32'h555;
    s_res[0] = 1; s_rreg[0] = 4;
    drive();
    edge_step();
    idle(0);
    s_rr[0][0] = 3; s_rr[0][1] = 4;
    drive();
    #2;
    chk("prerst R3", act_rd(0, 0), 32'h12345678);
    chk("prerst pend R4", act_pend(0, 1), 1);
    chk("prerst writeToPC", act_wtp(0), 1);
    chk("prerst pcWriteData", act_pcw(0), 32'h555);
    reset = 1'b0;
    #1;
    chk("rst R3", act_rd(0, 0), 0);
    chk("rst pend R4", act_pend(0, 1), 0);
    chk("rst writeToPC", act_wtp(0), 0);
    chk("rst pcWriteData", act_pcw(0), 0);
    model_reset();
    check_all("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    edge_step();

    // instance B: four independent ports, PC at index 7
    idle(0); idle(1);
    s_we0[1] = 1; s_d0[1] = 6; s_dat0[1] = 32'hAAAA; s_pc[1] = 32'hFFFC;
    s_rr[1][0] = 6; s_rr[1][1] = 7; s_rr[1][2] = 2; s_rr[1][3] = 0;
    drive();
    @(negedge clk);
    chk("B bypass p0", act_rd(1, 0), 32'hAAAA);
    chk("B pc wrap p1", act_rd(1, 1), 32'h0004);
    chk("B R2 p2", act_rd(1, 2), 0);
    check_all("B1");
    edge_step();
    idle(1);
    s_we1[1] = 1; s_d1[1] = 7; s_dat1[1] = 32'h200; s_pc[1] = 32'h100;
    s_rr[1][0] = 2; s_rr[1][1] = 6; s_rr[1][2] = 7; s_rr[1][3] = 6;
    drive();
    @(negedge clk);
    chk("B p1 R6", act_rd(1, 1), 32'hAAAA);
    chk("B p2 pc", act_rd(1, 2), 32'h108);
    chk("B p3 R6", act_rd(1, 3), 32'hAAAA);
    check_all("B2");
    edge_step();
    idle(1);
    drive();
    @(negedge clk);
    chk("B writeToPC pulse", act_wtp(1), 1);
    chk("B pcWriteData", act_pcw(1), 32'h200);
    edge_step();
    @(negedge clk);
    chk("B writeToPC end", act_wtp(1), 0);
    chk("B pcWriteData hold", act_pcw(1), 32'h200);
    edge_step();

    // randomized traffic on both instances against the model
    for (int k = 0; k < 400; k++) begin
      rand_stim(0);
      rand_stim(1);
      drive();
      @(negedge clk);
      check_all($sformatf("rnd%0d", k));
      edge_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised successor to the processor's 16-entry register file: configurable data width, register count and number of read ports, two write ports (ALU result and load/writeback), same-cycle write-through bypass, a per-register pending scoreboard for outstanding loads, and a registered PC-write pulse toward the program counter. It sits between decode (read addresses, reservations) and writeback (write ports). The top register is the PC and is not stored here.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 16, architectural registers; index NUM_REGS-1 is the PC
- NUM_READ, 3, read ports (min 1)
- PC_OFFSET, 8, added to pcIn when the PC is read
- ADDR_W, $clog2(NUM_REGS), register index width (derived)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- readRegs  in  NUM_READ*ADDR_W  flattened read indices; port i at [i*ADDR_W +: ADDR_W]
- readData  out  NUM_READ*DATA_W  flattened read data, same packing
- readPending  out  NUM_READ  1 = port i reads a register with an outstanding load
- writeEnable0 / writeDest0 / writeData0  in  1 / ADDR_W / DATA_W  write port 0 (ALU)
- writeEnable1 / writeDest1 / writeData1  in  1 / ADDR_W / DATA_W  write port 1 (load writeback); also clears pending
- reserveEn / reserveReg  in  1 / ADDR_W  mark register pending (load issued)
- pcIn  in  DATA_W  current PC from the program counter
- writeToPC  out  1  registered one-cycle pulse: PC was written
- pcWriteData  out  DATA_W  value for the PC, valid while writeToPC=1

## Operation
- Storage: NUM_REGS-1 registers of DATA_W, plus pend[NUM_REGS-2:0].
- Write: on posedge, register r loads writeDataK if writeEnableK and writeDestK==r. Both ports to same r: port 0 wins.
- PC write: any enabled port with dest NUM_REGS-1 -> next cycle writeToPC=1, pcWriteData = that data (port 0 wins if both). Otherwise writeToPC=0 next cycle; pcWriteData holds last value.
- Read (combinational), port i index a:
  - a==NUM_REGS-1 -> pcIn + PC_OFFSET, modulo 2^DATA_W; readPending[i]=0.
  - else if writeEnable0 && writeDest0==a -> writeData0 (bypass, port 0 priority).
  - else if writeEnable1 && writeDest1==a -> writeData1.
  - else stored value.
- Scoreboard: on posedge, pend[r] set if reserveEn && reserveReg==r; cleared if writeEnable1 && writeDest1==r; both same cycle -> set wins. Port 0 writes do not touch pend. reserveReg==NUM_REGS-1 ignored.
- readPending[i] = pend[a] && !(writeEnable1 && writeDest1==a) (bypassed load value is valid).
- Out-of-range indices (NUM_REGS not power of 2): reads return 0, writes/reservations ignored.

## Timing
- Reset (reset=0, asynchronous): all registers 0, pend all 0, writeToPC=0, pcWriteData=0, immediately, mid-operation included. Release synchronous to next posedge behaviour; first write accepted at first posedge with reset=1.
- Read latency 0 (combinational incl. bypass); write visible in storage 1 cycle after the edge.
- writeToPC: exactly 1 cycle after the write edge, 1 cycle wide; back-to-back PC writes give consecutive pulses.
- Reservation visible on readPending the cycle after reserveEn.

## Test plan
- Reset: write R3=0x12345678, assert reset low between edges -> readData for R3 = 0 immediately, pend cleared, writeToPC=0.
- Write/read: port0 writes R8=0xAAAAAAAA; next cycle readRegs port1=8 -> 0xAAAAAAAA; same cycle as write with read port0=8 -> bypass 0xAAAAAAAA.
- Conflict: port0 R2=0x11, port1 R2=0x22 same edge -> R2=0x11; pend[2] previously set -> cleared.
- Scoreboard: reserve R5; next cycle readPending for R5=1; port1 writes R5=0xCC -> that cycle readPending=0, readData=0xCC; reserve+clear R5 same edge -> pend stays 1.
- PC: pcIn=0x100, read index 15 -> 0x108; pcIn=0xFFFFFFFC -> 0x00000004; port1 writes R15=0x200 -> next cycle writeToPC=1, pcWriteData=0x200, then writeToPC=0.
- Parameters: DATA_W=16, NUM_REGS=8, NUM_READ=4 -> repeat write/read and PC scenarios (PC index 7), all four ports independent.
